// File: rtl/pipeline_mem_sb.sv
// MEM stage with a posted store buffer in front of a single-port byte-enabled data RAM.
// Define PIPELINE_MEM_SB_FWD_EN for byte-granular store-to-load forwarding; otherwise buffer hits raise a load hazard.
module pipeline_mem_sb #(
   parameter int ADDR_WIDTH = 10,
   parameter int SB_DEPTH   = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [31:0]               rt_value,
   input  logic [31:0]               rd_value,
   input  logic [1:0]                maccess_width,
   input  logic                      maccess_zext,
   input  logic                      memread_enable,
   input  logic                      memwrite_enable,
   input  logic                      alu_memop_disable,
   input  logic                      has_final_exception,
   output logic [31:0]               out_value,
   output logic [2:0]                exception,
   output logic [$clog2(SB_DEPTH):0] sb_count,
   output logic                      sb_empty
);
   localparam int PW        = $clog2(SB_DEPTH);
   localparam int CW        = PW + 1;
   localparam int RAM_WORDS = 1 << ADDR_WIDTH;

   localparam logic [1:0] W_BYTE = 2'd0;
   localparam logic [1:0] W_HALF = 2'd1;
   localparam logic [1:0] W_WORD = 2'd2;

   localparam logic [2:0] EXC_NONE  = 3'd0;
   localparam logic [2:0] EXC_LDADR = 3'd1;
   localparam logic [2:0] EXC_STADR = 3'd2;
   localparam logic [2:0] EXC_FULL  = 3'd3;
   localparam logic [2:0] EXC_HAZ   = 3'd4;

   function automatic logic misaligned(input logic [1:0] w, input logic [1:0] a);
      case (w)
         W_BYTE:  misaligned = 1'b0;
         W_HALF:  misaligned = a[0];
         W_WORD:  misaligned = (a != 2'b00);
         default: misaligned = 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] lane_be(input logic [1:0] w, input logic [1:0] a);
      case (w)
         W_BYTE:  lane_be = 4'b0001 << a;
         W_HALF:  lane_be = a[1] ? 4'b1100 : 4'b0011;
         default: lane_be = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] lane_data(input logic [1:0] w, input logic [31:0] d);
      case (w)
         W_BYTE:  lane_data = {4{d[7:0]}};
         W_HALF:  lane_data = {2{d[15:0]}};
         default: lane_data = d;
      endcase
   endfunction

   logic [31:0]           ram_q     [RAM_WORDS];
   logic [ADDR_WIDTH-1:0] sb_addr_q [SB_DEPTH];
   logic [3:0]            sb_be_q   [SB_DEPTH];
   logic [31:0]           sb_data_q [SB_DEPTH];

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic          empty_q, empty_d;

   logic [31:0] ram_dout_q;
   logic [1:0]  lane_q;
   logic [1:0]  width_q;
   logic        zext_q;

   logic                  ld_s, st_s, misalign_s, full_s;
   logic                  ld_ok_s, st_ok_s, drain_s, hazard_s;
   logic [ADDR_WIDTH-1:0] waddr_s;
   logic [PW-1:0]         slot_s [SB_DEPTH];
   logic [SB_DEPTH-1:0]   match_s;
   logic [31:0]           merged_s;
   logic [2:0]            exc_s;
   logic [31:0]           out_s;
   logic [7:0]            byte_s;
   logic [15:0]           half_s;
   logic                  unused_s;

   assign ld_s       = memread_enable  & ~alu_memop_disable & ~has_final_exception;
   assign st_s       = memwrite_enable & ~alu_memop_disable & ~has_final_exception;
   assign misalign_s = misaligned(maccess_width, rd_value[1:0]);
   assign full_s     = (count_q == CW'(SB_DEPTH));
   assign waddr_s    = rd_value[ADDR_WIDTH+1:2];
   assign ld_ok_s    = ld_s & ~misalign_s;
   assign st_ok_s    = st_s & ~misalign_s & ~full_s;
   // The RAM port is only free for a drain when the pipeline issues no memory op at all.
   assign drain_s    = ~ld_s & ~st_s & (count_q != CW'(0));
   assign unused_s   = ^rd_value[31:ADDR_WIDTH+2];

   // Index i is the i-th oldest entry; match only entries that are currently occupied.
   always_comb begin
      for (int i = 0; i < SB_DEPTH; i++) begin
         slot_s[i]  = head_q + PW'(i);
         match_s[i] = (CW'(i) < count_q) && (sb_addr_q[slot_s[i]] == waddr_s);
      end
   end

`ifdef PIPELINE_MEM_SB_FWD_EN
   logic [3:0]  ovl_mask_q, ovl_mask_d;
   logic [31:0] ovl_data_q, ovl_data_d;

   // Walk oldest to newest so the youngest store owns each byte it enables.
   always_comb begin
      ovl_mask_d = 4'b0000;
      ovl_data_d = 32'h0000_0000;
      for (int i = 0; i < SB_DEPTH; i++) begin
         for (int b = 0; b < 4; b++) begin
            ovl_mask_d[b]       = ovl_mask_d[b] | (match_s[i] & sb_be_q[slot_s[i]][b]);
            ovl_data_d[8*b +: 8] = (match_s[i] & sb_be_q[slot_s[i]][b]) ?
                                   sb_data_q[slot_s[i]][8*b +: 8] : ovl_data_d[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovl_mask_q <= 4'b0000;
         ovl_data_q <= 32'h0000_0000;
      end else if (ld_ok_s) begin
         ovl_mask_q <= ovl_mask_d;
         ovl_data_q <= ovl_data_d;
      end
   end

   always_comb begin
      for (int b = 0; b < 4; b++) begin
         merged_s[8*b +: 8] = ovl_mask_q[b] ? ovl_data_q[8*b +: 8] : ram_dout_q[8*b +: 8];
      end
   end

   assign hazard_s = 1'b0;
`else
   assign merged_s = ram_dout_q;
   assign hazard_s = |match_s;
`endif

   always_comb begin
      if (ld_s && misalign_s) begin
         exc_s = EXC_LDADR;
      end else if (st_s && misalign_s) begin
         exc_s = EXC_STADR;
      end else if (st_s && full_s) begin
         exc_s = EXC_FULL;
      end else if (ld_s && hazard_s) begin
         exc_s = EXC_HAZ;
      end else begin
         exc_s = EXC_NONE;
      end
   end

   assign exception = exc_s;

   // Enqueue and drain are mutually exclusive, so the count moves by at most one.
   always_comb begin
      head_d = drain_s ? head_q + PW'(1) : head_q;
      tail_d = st_ok_s ? tail_q + PW'(1) : tail_q;
      case ({st_ok_s, drain_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      empty_d = (count_d == CW'(0));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         empty_q <= 1'b1;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         empty_q <= empty_d;
      end
   end

   always_ff @(posedge clk) begin
      if (st_ok_s) begin
         sb_addr_q[tail_q] <= waddr_s;
         sb_be_q[tail_q]   <= lane_be(maccess_width, rd_value[1:0]);
         sb_data_q[tail_q] <= lane_data(maccess_width, rt_value);
      end
   end

   always_ff @(posedge clk) begin
      if (drain_s) begin
         for (int b = 0; b < 4; b++) begin
            if (sb_be_q[head_q][b]) begin
               ram_q[sb_addr_q[head_q]][8*b +: 8] <= sb_data_q[head_q][8*b +: 8];
            end
         end
      end
   end

   // Read data and lane controls only move on an accepted load, so out_value holds otherwise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ram_dout_q <= 32'h0000_0000;
         lane_q     <= 2'b00;
         width_q    <= 2'b00;
         zext_q     <= 1'b0;
      end else if (ld_ok_s) begin
         ram_dout_q <= ram_q[waddr_s];
         lane_q     <= rd_value[1:0];
         width_q    <= maccess_width;
         zext_q     <= maccess_zext;
      end
   end

   always_comb begin
      byte_s = merged_s[{lane_q, 3'b000} +: 8];
      half_s = merged_s[{lane_q[1], 4'b0000} +: 16];
      case (width_q)
         W_BYTE:  out_s = {{24{~zext_q & byte_s[7]}}, byte_s};
         W_HALF:  out_s = {{16{~zext_q & half_s[15]}}, half_s};
         default: out_s = merged_s;
      endcase
   end

   assign out_value = out_s;
   assign sb_count  = count_q;
   assign sb_empty  = empty_q;

endmodule

// File: tb/tb_pipeline_mem_sb.sv
// Self-checking bench for pipeline_mem_sb: directed scenarios plus random traffic against
// a byte-addressed memory model (architectural view and physical RAM view).
module tb_pipeline_mem_sb;
   localparam int SB = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] rt_value = 32'h0, rd_value = 32'h0, out_value;
   logic [1:0]  maccess_width = 2'd0;
   logic        maccess_zext = 1'b0, memread_enable = 1'b0, memwrite_enable = 1'b0;
   logic        alu_memop_disable = 1'b0, has_final_exception = 1'b0;
   logic [2:0]  exception;
   logic [2:0]  sb_count;
   logic        sb_empty;

   pipeline_mem_sb #(.ADDR_WIDTH(10), .SB_DEPTH(SB)) dut (
      .clk(clk), .rst(rst), .rt_value(rt_value), .rd_value(rd_value),
      .maccess_width(maccess_width), .maccess_zext(maccess_zext),
      .memread_enable(memread_enable), .memwrite_enable(memwrite_enable),
      .alu_memop_disable(alu_memop_disable), .has_final_exception(has_final_exception),
      .out_value(out_value), .exception(exception), .sb_count(sb_count), .sb_empty(sb_empty)
   );

   always #5 clk = ~clk;

   typedef struct { int a; int n; logic [31:0] d; } st_t;

   int          errors = 0;
   int          checks = 0;
   logic [7:0]  arch [256];
   logic [7:0]  phys [256];
   st_t         q [$];
   logic [31:0] exp_out = 32'h0;
   logic [2:0]  last_exc = 3'd0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int nbytes(input int w);
      return (w == 0) ? 1 : (w == 1) ? 2 : 4;
   endfunction

   function automatic logic [31:0] ld_val(input int a, input int w, input bit zx, input bit use_arch);
      logic [31:0] v;
      int n;
      n = nbytes(w);
      v = 32'h0;
      for (int k = 0; k < n; k++) begin
         v = v | (32'(use_arch ? arch[a + k] : phys[a + k]) << (8 * k));
      end
      if (!zx && n < 4 && v[8 * n - 1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
      return v;
   endfunction

   task automatic step(input bit ld, input bit st, input int w, input bit zx,
                       input int a, input logic [31:0] d, input bit ame, input bit hfe);
      bit ldq, stq, mis, hit;
      logic [2:0] ec;
      st_t e;
      @(negedge clk);
      memread_enable = ld; memwrite_enable = st; maccess_width = 2'(w); maccess_zext = zx;
      rd_value = 32'(a); rt_value = d; alu_memop_disable = ame; has_final_exception = hfe;
      ldq = ld && !ame && !hfe;
      stq = st && !ame && !hfe;
      mis = (w == 3) || (w == 1 && (a % 2) != 0) || (w == 2 && (a % 4) != 0);
      hit = 1'b0;
      foreach (q[i]) if ((q[i].a / 4) == (a / 4)) hit = 1'b1;
      if (ldq && mis) ec = 3'd1;
      else if (stq && mis) ec = 3'd2;
      else if (stq && q.size() == SB) ec = 3'd3;
`ifndef PIPELINE_MEM_SB_FWD_EN
      else if (ldq && hit) ec = 3'd4;
`endif
      else ec = 3'd0;
      #1;
      last_exc = exception;
      chk("exception", 32'(exception), 32'(ec));
`ifdef PIPELINE_MEM_SB_FWD_EN
      if (ldq && !mis) exp_out = ld_val(a, w, zx, 1'b1);
`else
      if (ldq && !mis) exp_out = ld_val(a, w, zx, 1'b0);
`endif
      if (stq && !mis && q.size() < SB) begin
         e.a = a; e.n = nbytes(w); e.d = d;
         q.push_back(e);
         for (int k = 0; k < e.n; k++) arch[a + k] = 8'(d >> (8 * k));
      end
      if (!ldq && !stq && q.size() > 0) begin
         e = q.pop_front();
         for (int k = 0; k < e.n; k++) phys[e.a + k] = 8'(e.d >> (8 * k));
      end
      @(posedge clk);
      #1;
      chk("out_value", out_value, exp_out);
      chk("sb_count", 32'(sb_count), 32'(q.size()));
      chk("sb_empty", 32'(sb_empty), 32'(q.size() == 0));
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 0, 1'b0, 0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      memread_enable = 1'b0; memwrite_enable = 1'b0;
      rst = 1'b0;
      #1;
      chk("rst_count", 32'(sb_count), 32'd0);
      chk("rst_empty", 32'(sb_empty), 32'd1);
      chk("rst_out", out_value, 32'h0);
      q.delete();
      arch = phys;
      exp_out = 32'h0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      int r, w, a;
      logic [31:0] d;
      for (int i = 0; i < 256; i++) begin arch[i] = 8'h0; phys[i] = 8'h0; end
      do_reset();

      for (int i = 0; i < 64; i++) begin
         d = $urandom;
         step(1'b0, 1'b1, 2, 1'b0, i * 4, d, 1'b0, 1'b0);
         idle();
      end

      // store then immediate load of the same word
      step(1'b0, 1'b1, 2, 1'b0, 32'h40, 32'hDEADBEEF, 1'b0, 1'b0);
      step(1'b1, 1'b0, 2, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0);
`ifdef PIPELINE_MEM_SB_FWD_EN
      chk("tp1_fwd", out_value, 32'hDEADBEEF);
`else
      chk("tp1_hazard", 32'(last_exc), 32'd4);
`endif
      chk("tp1_cnt1", 32'(sb_count), 32'd1);
      idle();
      chk("tp1_cnt0", 32'(sb_count), 32'd0);

      // newest byte wins
      step(1'b0, 1'b1, 2, 1'b0, 32'h80, 32'h11223344, 1'b0, 1'b0);
      step(1'b0, 1'b1, 0, 1'b0, 32'h81, 32'h000000AA, 1'b0, 1'b0);
      step(1'b0, 1'b1, 0, 1'b0, 32'h81, 32'h000000BB, 1'b0, 1'b0);
      step(1'b1, 1'b0, 2, 1'b0, 32'h80, 32'h0, 1'b0, 1'b0);
`ifdef PIPELINE_MEM_SB_FWD_EN
      chk("tp2_fwd", out_value, 32'h1122BB44);
`endif
      idle(); idle(); idle();
      step(1'b1, 1'b0, 2, 1'b0, 32'h80, 32'h0, 1'b0, 1'b0);
      chk("tp2_ram", out_value, 32'h1122BB44);

      // overflow: the (SB+1)th store is dropped
      for (int i = 0; i <= SB; i++) begin
         step(1'b0, 1'b1, 2, 1'b0, i * 4, (i == SB) ? 32'hCAFEF00D : $urandom, 1'b0, 1'b0);
      end
      chk("tp3_full_exc", 32'(last_exc), 32'd3);
      chk("tp3_full_cnt", 32'(sb_count), 32'(SB));
      for (int i = 0; i < SB + 1; i++) idle();
      step(1'b1, 1'b0, 2, 1'b0, SB * 4, 32'h0, 1'b0, 1'b0);

      // sub-word load extension and misaligned half
      step(1'b0, 1'b1, 0, 1'b0, 32'h83, 32'h00000080, 1'b0, 1'b0);
      idle();
      step(1'b1, 1'b0, 0, 1'b0, 32'h83, 32'h0, 1'b0, 1'b0);
      chk("tp4_sext", out_value, 32'hFFFFFF80);
      step(1'b1, 1'b0, 0, 1'b1, 32'h83, 32'h0, 1'b0, 1'b0);
      chk("tp4_zext", out_value, 32'h00000080);
      step(1'b1, 1'b0, 1, 1'b0, 32'h81, 32'h0, 1'b0, 1'b0);
      chk("tp4_mis_exc", 32'(last_exc), 32'd1);
      chk("tp4_mis_hold", out_value, 32'h00000080);

      // cancelled store
      step(1'b0, 1'b1, 2, 1'b0, 32'h40, 32'h12345678, 1'b0, 1'b1);
      chk("tp5_exc", 32'(last_exc), 32'd0);
      chk("tp5_cnt", 32'(sb_count), 32'd0);
      step(1'b1, 1'b0, 2, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0);
      chk("tp5_ram", out_value, 32'hDEADBEEF);

      // reset with stores pending
      step(1'b0, 1'b1, 2, 1'b0, 32'hC0, 32'h01010101, 1'b0, 1'b0);
      step(1'b0, 1'b1, 2, 1'b0, 32'hC4, 32'h02020202, 1'b0, 1'b0);
      step(1'b0, 1'b1, 2, 1'b0, 32'hC8, 32'h03030303, 1'b0, 1'b0);
      idle();
      do_reset();
      step(1'b1, 1'b0, 2, 1'b0, 32'hC4, 32'h0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 2, 1'b0, 32'hC8, 32'h0, 1'b0, 1'b0);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 9);
         w = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
         a = $urandom_range(0, 255);
         if (w != 3 && $urandom_range(0, 3) != 0) a = a - (a % nbytes(w));
         d = $urandom;
         if ($urandom_range(0, 149) == 0) do_reset();
         step(r < 4, (r >= 4) && (r < 7), w, 1'(($urandom_range(0, 1))), a, d,
              $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
